// File: rtl/esp8266_pkg.sv
// Shared encodings for the ESP8266 response decoder: FSM states, line-match codes,
// ASCII constants, the literal response lines and the optional command codes.
package esp8266_pkg;

    typedef enum logic [1:0] {
        ST_LINE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MATCH_NONE  = 2'd0,
        MATCH_OK    = 2'd1,
        MATCH_ERR   = 2'd2,
        MATCH_READY = 2'd3
    } match_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_QUOTE = 8'h22;

    // Literals are packed first-character-high, matching a left-shifting byte history.
    localparam int LIT_BYTES = 6;
    localparam logic [23:0] LIT_OK    = {"OK", ASCII_CR};
    localparam logic [47:0] LIT_ERROR = {"ERROR", ASCII_CR};
    localparam logic [39:0] LIT_FAIL  = {"FAIL", ASCII_CR};
    localparam logic [47:0] LIT_READY = {"ready", ASCII_CR};
    localparam logic [39:0] LIT_IPD   = {"+IPD", ASCII_COMMA};

    localparam logic [2:0] CMD_PLAY  = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_UP    = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;
    localparam logic [2:0] CMD_ON    = 3'd5;
    localparam logic [2:0] CMD_OFF   = 3'd6;
    localparam logic [2:0] CMD_OTHER = 3'd7;

    localparam logic [39:0] CMD_PREFIX = {ASCII_QUOTE, "C", ASCII_QUOTE, ASCII_COLON, ASCII_QUOTE};

    // tlen saturates at 5, so any over-long token falls through to CMD_OTHER.
    function automatic logic [2:0] cmd_lookup(input logic [31:0] tok, input logic [2:0] tlen);
        logic [2:0] code;
        code = CMD_OTHER;
        case (tlen)
            3'd2: begin
                if (tok[15:0] == "up")      code = CMD_UP;
                else if (tok[15:0] == "on") code = CMD_ON;
            end
            3'd3: begin
                if (tok[23:0] == "off") code = CMD_OFF;
            end
            3'd4: begin
                if (tok == "play")      code = CMD_PLAY;
                else if (tok == "stop") code = CMD_STOP;
                else if (tok == "down") code = CMD_DOWN;
            end
            default: code = CMD_OTHER;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/esp8266_line_match.sv
// Line buffer for the ESP8266 decoder: tracks the current line and flags OK/ERROR/FAIL/ready
// on the terminating '\n', plus the "+IPD," header as soon as its ',' arrives.
module esp8266_line_match
    import esp8266_pkg::*;
#(
    parameter int LINE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       active,
    output match_t     match,
    output logic       ipd_hdr
);

    localparam int            LW      = $clog2(LINE_MAX + 1);
    localparam logic [LW-1:0] LEN_SAT = LW'(LINE_MAX);

    // Only the newest LIT_BYTES bytes can ever take part in a match; the length
    // counter alone decides whether the line is exactly a literal or saturated.
    logic [8*LIT_BYTES-1:0] tail_q;
    logic [8*LIT_BYTES-1:0] tail_next;
    logic [LW-1:0]          len_q;
    logic [LW-1:0]          len_next;
    logic                   is_lf;
    logic                   take;

    assign is_lf     = (rx_data == ASCII_LF);
    assign take      = active && rx_valid;
    assign tail_next = {tail_q[8*LIT_BYTES-9:0], rx_data};
    assign len_next  = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        match = MATCH_NONE;
        if (take && is_lf && len_q != LEN_SAT) begin
            if (len_q == LW'(3) && tail_q[23:0] == LIT_OK) begin
                match = MATCH_OK;
            end else if (len_q == LW'(6) && tail_q == LIT_ERROR) begin
                match = MATCH_ERR;
            end else if (len_q == LW'(5) && tail_q[39:0] == LIT_FAIL) begin
                match = MATCH_ERR;
            end else if (len_q == LW'(6) && tail_q == LIT_READY) begin
                match = MATCH_READY;
            end
        end
    end

    assign ipd_hdr = take && !is_lf && (len_q != LEN_SAT) &&
                     (len_next == LW'(5)) && (tail_next[39:0] == LIT_IPD);

    // NOTE: the buffer is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_q <= '0;
            len_q  <= '0;
        end else if (!active || (rx_valid && (is_lf || ipd_hdr))) begin
            tail_q <= '0;
            len_q  <= '0;
        end else if (rx_valid) begin
            tail_q <= tail_next;
            len_q  <= len_next;
        end
    end

endmodule

// File: rtl/esp8266_decode.sv
// ESP8266 UART RX decoder: response-line classification and +IPD frame extraction.
// Optional "C" command matcher inside payloads is built when ESP_DEC_CMD_EN is defined.
module esp8266_decode
    import esp8266_pkg::*;
#(
    parameter int          MAX_LEN     = 512,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
    parameter int          LINE_MAX    = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  Rx_data,
    input  logic        Rx_valid,
    output logic        Ok_pulse,
    output logic        Err_pulse,
    output logic        Ready_pulse,
    output logic        Ipd_start,
    output logic [15:0] Ipd_len,
    output logic [7:0]  Ipd_data,
    output logic        Ipd_valid,
    output logic        Ipd_done,
    output logic        Ipd_abort
`ifdef ESP_DEC_CMD_EN
    ,
    output logic        Cmd_valid,
    output logic [2:0]  Cmd_code
`endif
);

    state_t      state_q, state_d;
    logic [16:0] acc_q, acc_d, acc_mul;
    logic [2:0]  ndig_q, ndig_d;
    logic [15:0] rem_q, rem_d;
    logic [23:0] idle_q, idle_d;
    logic        ok_d, err_d, ready_d, start_d, valid_d, done_d, abort_d;
    logic [15:0] len_d;
    logic [7:0]  data_d;
    logic        is_digit;
    logic        timed_out;
    match_t      lm_match;
    logic        lm_hdr;

    esp8266_line_match #(
        .LINE_MAX (LINE_MAX)
    ) u_line (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .rx_data  (Rx_data),
        .rx_valid (Rx_valid),
        .active   (state_q == ST_LINE),
        .match    (lm_match),
        .ipd_hdr  (lm_hdr)
    );

    assign is_digit  = (Rx_data >= ASCII_0) && (Rx_data <= ASCII_9);
    assign acc_mul   = acc_q * 17'd10 + {13'd0, Rx_data[3:0]};
    assign timed_out = (idle_q == TIMEOUT_CYC - 24'd1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ndig_d  = ndig_q;
        rem_d   = rem_q;
        idle_d  = '0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        ready_d = 1'b0;
        start_d = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        len_d   = Ipd_len;
        data_d  = Ipd_data;

        case (state_q)
            ST_LINE: begin
                if (Rx_valid) begin
                    ok_d    = (lm_match == MATCH_OK);
                    err_d   = (lm_match == MATCH_ERR);
                    ready_d = (lm_match == MATCH_READY);
                    if (lm_hdr) begin
                        state_d = ST_LEN;
                        acc_d   = '0;
                        ndig_d  = '0;
                    end
                end
            end

            ST_LEN: begin
                if (Rx_valid) begin
                    if (is_digit) begin
                        if (ndig_q == 3'd5 || acc_mul > 17'(MAX_LEN)) begin
                            abort_d = 1'b1;
                            state_d = ST_LINE;
                        end else begin
                            acc_d  = acc_mul;
                            ndig_d = ndig_q + 3'd1;
                        end
                    end else if (Rx_data == ASCII_COLON && ndig_q != 3'd0) begin
                        start_d = 1'b1;
                        len_d   = acc_q[15:0];
                        if (acc_q == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_LINE;
                        end else begin
                            rem_d   = acc_q[15:0];
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        abort_d = 1'b1;
                        state_d = ST_LINE;
                    end
                end else if (timed_out) begin
                    abort_d = 1'b1;
                    state_d = ST_LINE;
                end else begin
                    idle_d = idle_q + 24'd1;
                end
            end

            ST_PAYLOAD: begin
                if (Rx_valid) begin
                    valid_d = 1'b1;
                    data_d  = Rx_data;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_LINE;
                    end
                end else if (timed_out) begin
                    abort_d = 1'b1;
                    state_d = ST_LINE;
                end else begin
                    idle_d = idle_q + 24'd1;
                end
            end

            default: state_d = ST_LINE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_LINE;
            acc_q       <= '0;
            ndig_q      <= '0;
            rem_q       <= '0;
            idle_q      <= '0;
            Ok_pulse    <= 1'b0;
            Err_pulse   <= 1'b0;
            Ready_pulse <= 1'b0;
            Ipd_start   <= 1'b0;
            Ipd_len     <= '0;
            Ipd_data    <= '0;
            Ipd_valid   <= 1'b0;
            Ipd_done    <= 1'b0;
            Ipd_abort   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ndig_q      <= ndig_d;
            rem_q       <= rem_d;
            idle_q      <= idle_d;
            Ok_pulse    <= ok_d;
            Err_pulse   <= err_d;
            Ready_pulse <= ready_d;
            Ipd_start   <= start_d;
            Ipd_len     <= len_d;
            Ipd_data    <= data_d;
            Ipd_valid   <= valid_d;
            Ipd_done    <= done_d;
            Ipd_abort   <= abort_d;
        end
    end

`ifdef ESP_DEC_CMD_EN
    // Command matcher: a 4-byte history finds the "C":" prefix, then the token is
    // collected until the closing quote. Leaving PAYLOAD for any reason wipes it.
    logic [31:0] hist_q, hist_d;
    logic [31:0] tok_q, tok_d;
    logic [2:0]  tlen_q, tlen_d;
    logic        in_tok_q, in_tok_d;
    logic        cmd_valid_d;
    logic [2:0]  cmd_code_d;

    always_comb begin
        hist_d      = hist_q;
        tok_d       = tok_q;
        tlen_d      = tlen_q;
        in_tok_d    = in_tok_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = Cmd_code;
        if (state_q != ST_PAYLOAD) begin
            hist_d   = '0;
            tok_d    = '0;
            tlen_d   = '0;
            in_tok_d = 1'b0;
        end else if (Rx_valid) begin
            if (in_tok_q) begin
                if (Rx_data == ASCII_QUOTE) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = cmd_lookup(tok_q, tlen_q);
                    hist_d      = '0;
                    tok_d       = '0;
                    tlen_d      = '0;
                    in_tok_d    = 1'b0;
                end else begin
                    tok_d = {tok_q[23:0], Rx_data};
                    if (tlen_q != 3'd5) tlen_d = tlen_q + 3'd1;
                end
            end else begin
                hist_d = {hist_q[23:0], Rx_data};
                if ({hist_q, Rx_data} == CMD_PREFIX) begin
                    in_tok_d = 1'b1;
                    tok_d    = '0;
                    tlen_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hist_q    <= '0;
            tok_q     <= '0;
            tlen_q    <= '0;
            in_tok_q  <= 1'b0;
            Cmd_valid <= 1'b0;
            Cmd_code  <= '0;
        end else begin
            hist_q    <= hist_d;
            tok_q     <= tok_d;
            tlen_q    <= tlen_d;
            in_tok_q  <= in_tok_d;
            Cmd_valid <= cmd_valid_d;
            Cmd_code  <= cmd_code_d;
        end
    end
`endif

endmodule

// File: doc/esp8266_decode.md
Name: esp8266_decode

Overview:
Receive-side counterpart of the ESP8266 AT encoder. Consumes the UART RX byte stream from the module and classifies response lines as OK, ERROR or ready. Extracts "+IPD,<len>:<payload>" frames into a length-counted byte stream with start/done/abort markers. Sits between the UART receiver and the bigiot control logic.

Parameters:
MAX_LEN, 512, largest accepted +IPD payload length; larger lengths abort the frame
TIMEOUT_CYC, 24'd5_000_000, idle clocks allowed between payload bytes before abort (100 ms at 50 MHz)
LINE_MAX, 8, longest line, including "\r", held for OK/ERROR/ready comparison

Ports:
Clk  input  1  system clock
Rst_n  input  1  reset; asynchronous, active-low
Rx_data  input  8  received byte
Rx_valid  input  1  one-cycle strobe; Rx_data is valid in the same cycle
Ok_pulse  output  1  one cycle after the '\n' that ends the line "OK\r"
Err_pulse  output  1  one cycle after the '\n' that ends "ERROR\r" or "FAIL\r"
Ready_pulse  output  1  one cycle after the '\n' that ends "ready\r"
Ipd_start  output  1  one-cycle pulse when ':' of a valid header is accepted
Ipd_len  output  16  parsed payload length; held from Ipd_start until the next Ipd_start
Ipd_data  output  8  payload byte
Ipd_valid  output  1  one-cycle strobe per payload byte
Ipd_done  output  1  pulse, same cycle as the last Ipd_valid
Ipd_abort  output  1  one-cycle pulse on any frame error or timeout

Behaviour:
- Reset: all outputs 0, state LINE, line buffer empty, counters 0. Reset asserted mid-frame discards the frame and raises no pulse.
- All outputs are registered. The response latency is 1 clock after the Rx_valid cycle that completes an event.
- State LINE:
  - Appends bytes to the line buffer; the line length saturates at LINE_MAX, and a saturated line never matches.
  - On '\n': compare the whole buffer, fire the matching pulse, then clear the buffer.
  - When the buffer content equals "+IPD," go to LEN, clear the accumulator and clear the digit count.
- State LEN:
  - Digit '0'-'9': acc <= acc*10 + digit, using 17-bit internal width.
  - More than 5 digits, or acc > MAX_LEN: Ipd_abort, go to LINE.
  - ':' with at least 1 digit:
    - acc==0: Ipd_start and Ipd_done in the same cycle, go to LINE.
    - otherwise: Ipd_start, Ipd_len<=acc, remaining<=acc, go to PAYLOAD.
  - Any other byte, or ':' with no digits: Ipd_abort, go to LINE.
- State PAYLOAD:
  - Each Rx_valid gives Ipd_valid with Ipd_data<=Rx_data and decrements remaining.
  - When remaining reaches 1→0: Ipd_done, go to LINE.
  - Payload bytes are never line-matched; "OK\r\n" inside a payload does not fire Ok_pulse.
- Timeout: the idle counter runs in LEN and PAYLOAD and resets on each Rx_valid. At TIMEOUT_CYC it raises Ipd_abort and goes to LINE. It is held at 0 in LINE.
- Only one pulse output is active per cycle, except Ipd_start+Ipd_done for a zero-length frame and Ipd_valid+Ipd_done on the last byte.
- On entry to LINE the line buffer is cleared, so the first line after a frame is parsed from its first byte.

Optional Feature:
ESP_DEC_CMD_EN
- Defined: adds outputs Cmd_valid (1) and Cmd_code (3). While in PAYLOAD, the block matches "\"C\":\"" followed by one of the tokens below, terminated by '"':
  - play=1, stop=2, up=3, down=4, on=5, off=6; anything else is code 7.
  - Cmd_valid pulses for one cycle after the closing '"'. Cmd_code holds until the next Cmd_valid.
  - A frame abort cancels any partial match.
- Undefined: the ports are absent, with no matcher logic and no change to the other behaviour.

Decomposition:
- Package esp8266_pkg holds:
  - state encoding (LINE, LEN, PAYLOAD)
  - ASCII constants ('\r', '\n', ':', ',', '0')
  - Cmd_code values
  - the line literals "OK\r", "ERROR\r", "FAIL\r", "ready\r", "+IPD,"
- Sub-module esp8266_line_match holds the line buffer, length counter and literal comparators. It outputs a per-'\n' match code plus an ipd_hdr hit. The parent owns the frame FSM, length parser, timeout and optional command matcher.

Test Plan:
1. Bytes "OK\r\n" -> exactly one Ok_pulse, one clock after the '\n' strobe; no other pulses.
2. "AT\r\nERROR\r\n" -> no pulse on the first line; Err_pulse after the second '\n'.
3. "+IPD,5:OK\r\nx" -> Ipd_start with Ipd_len=5; Ipd_valid ×5 with data 4F,4B,0D,0A,78; Ipd_done on the 5th byte; Ok_pulse never fires.
4. "+IPD,0:" then "OK\r\n" -> Ipd_start+Ipd_done in the same cycle, then one Ok_pulse.
5. "+IPD,600:", "+IPD,1a:" and "+IPD,:" -> one Ipd_abort each and no Ipd_start; a following "ready\r\n" gives Ready_pulse.
6. "+IPD,10:abc" then idle for TIMEOUT_CYC -> Ipd_abort, with no Ipd_done. Repeat with Rst_n low after byte 'b' -> no pulses, state LINE.
